// File: rtl/mem_port_arbiter.sv
// Round-robin memory request-port arbiter with burst ownership and a post-burst turnaround gap.
// Optional ARB_DECODER_PRIO_EN: requester 0 wins every decision and does not rotate the pointer.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BLEN_W  = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*BLEN_W-1:0]   burst_len,
  input  logic                        mem_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy,
  output logic                        beat_last,
  output logic                        abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [BLEN_W-1:0]  cnt;
  logic [BLEN_W-1:0]  blen_q;

  logic [ID_W-1:0]    win;
  logic [BLEN_W-1:0]  blen_sel;
  logic [ID_W-1:0]    ptr_after;
  logic               last_hit;
  logic               drop_hit;

  // First set request at or after ptr, searching cyclically; lower offsets win.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                           input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] w;
    int              idx;
    w = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (r[idx]) w = ID_W'(idx);
    end
    return w;
  endfunction

`ifdef ARB_DECODER_PRIO_EN
  assign win = req[0] ? '0 : pick(req, rr_ptr);
`else
  assign win = pick(req, rr_ptr);
`endif

  assign blen_sel = burst_len[int'(win)*BLEN_W +: BLEN_W];

  always_comb begin
    ptr_after = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
`ifdef ARB_DECODER_PRIO_EN
    // The decoder bypasses rotation so the others keep their turn order.
    if (grant_id == '0) ptr_after = rr_ptr;
`endif
  end

  // A last beat coinciding with a request drop completes normally rather than aborting.
  assign last_hit  = !reset && (state == OWN) && mem_ready && (cnt == blen_q);
  assign drop_hit  = !reset && (state == OWN) && !req[grant_id] && !last_hit;
  assign beat_last = last_hit;
  assign abort     = drop_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= NUM_REQ'(1) << win;
            grant_id <= win;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (last_hit || drop_hit) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= ptr_after;
            state  <= GAP;
          end else if (mem_ready) begin
            cnt <= cnt + BLEN_W'(1);
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Burst length is captured only at the decision; later changes do not affect the burst.
  always_ff @(posedge clk) begin
    if (state == IDLE && |req) blen_q <= blen_sel;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
// Honours ARB_DECODER_PRIO_EN when the same macro is defined for the build.
module tb_mem_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int BLEN_W  = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*BLEN_W-1:0] burst_len;
  logic                      mem_ready;
  logic [NUM_REQ-1:0]        grant;
  logic [1:0]                grant_id;
  logic                      busy;
  logic                      beat_last;
  logic                      abort;

  int total = 0;
  int bad   = 0;

  // Reference model: owner (-1 when none), beats accepted so far, burst beats-1,
  // dead cycles still to wait before a decision, and the round-robin start index.
  int m_owner, m_id, m_done, m_len, m_dead, m_ptr;

  mem_port_arbiter #(.NUM_REQ(NUM_REQ), .BLEN_W(BLEN_W)) dut (
    .clk(clk), .reset(reset), .req(req), .burst_len(burst_len),
    .mem_ready(mem_ready), .grant(grant), .grant_id(grant_id), .busy(busy),
    .beat_last(beat_last), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int pick_winner(input logic [NUM_REQ-1:0] r, input int ptr);
`ifdef ARB_DECODER_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NUM_REQ; k++)
      if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return ptr;
  endfunction

  function automatic int rotate(input int owner, input int ptr);
`ifdef ARB_DECODER_PRIO_EN
    if (owner == 0) return ptr;
`endif
    return (owner + 1) % NUM_REQ;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_id = 0; m_done = 0; m_len = 0; m_dead = 0; m_ptr = 0;
  endtask

  // One clock: drive inputs after the falling edge, check, advance model, wait a full period.
  task automatic cyc(input logic [3:0] r, input logic [15:0] bl, input logic rdy, input logic rst);
    logic [3:0] e_grant;
    logic       e_last, e_abort;
    req = r; burst_len = bl; mem_ready = rdy; reset = rst;
    #1;
    e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    e_last  = !rst && (m_owner >= 0) && rdy && (m_done == m_len);
    e_abort = !rst && (m_owner >= 0) && !r[m_owner] && !e_last;
    chk("grant", 32'(grant), 32'(e_grant));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("beat_last", 32'(beat_last), 32'(e_last));
    chk("abort", 32'(abort), 32'(e_abort));
    chk("grant_id", 32'(grant_id), 32'(m_id));
    if (rst) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (e_last || e_abort) begin
        m_ptr = rotate(m_owner, m_ptr);
        m_owner = -1;
        m_dead = 1;
      end else if (rdy) begin
        m_done++;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else if (|r) begin
      m_owner = pick_winner(r, m_ptr);
      m_id    = m_owner;
      m_len   = int'((bl >> (m_owner * BLEN_W)) & 16'hF);
      m_done  = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(4'b0, 16'h0, 1'b0, 1'b1);
    cyc(4'b0, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0]  rr;
    logic [15:0] bb;
    req = '0; burst_len = '0; mem_ready = 1'b0; reset = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single requester, 4-beat burst.
    for (int i = 0; i < 7; i++) cyc(4'b0010, 16'h0030, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 16'h0030, 1'b1, 1'b0);

    // All requesting single-beat bursts: rotation order and gap spacing.
    do_reset();
    for (int i = 0; i < 22; i++) cyc(4'b1111, 16'h0000, 1'b1, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b1, 1'b0);

    // Stall on owner 2 with a 2-beat burst.
    do_reset();
    cyc(4'b0100, 16'h0100, 1'b0, 1'b0);
    cyc(4'b0100, 16'h0100, 1'b1, 1'b0);
    cyc(4'b0100, 16'h0100, 1'b0, 1'b0);
    cyc(4'b0100, 16'h0100, 1'b0, 1'b0);
    cyc(4'b0100, 16'h0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 16'h0100, 1'b1, 1'b0);

    // Abort: owner 3 drops after one of four beats; then 0 should win from rr_ptr=0.
    do_reset();
    cyc(4'b1000, 16'h3000, 1'b1, 1'b0);
    cyc(4'b1000, 16'h3000, 1'b1, 1'b0);
    cyc(4'b0000, 16'h3000, 1'b1, 1'b0);
    cyc(4'b0000, 16'h3000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b1001, 16'h0000, 1'b1, 1'b0);

    // Same-cycle drop and last beat: completion wins.
    do_reset();
    cyc(4'b0010, 16'h0000, 1'b1, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b1, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b1, 1'b0);

    // Reset mid-burst, then pending request 2 wins from rr_ptr=0.
    do_reset();
    cyc(4'b0010, 16'h0050, 1'b1, 1'b0);
    cyc(4'b0010, 16'h0050, 1'b1, 1'b0);
    cyc(4'b0010, 16'h0050, 1'b1, 1'b0);
    cyc(4'b0100, 16'h0050, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(4'b0100, 16'h0000, 1'b1, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b1, 1'b0);

    // Get rr_ptr to 2, then mixed requests including the decoder.
    do_reset();
    for (int i = 0; i < 2; i++) cyc(4'b0010, 16'h0000, 1'b1, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b1, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(4'b1110, 16'h0000, 1'b1, 1'b0);
    cyc(4'b1101, 16'h0000, 1'b1, 1'b0);
    cyc(4'b1101, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(4'b1101, 16'h0000, 1'b1, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b1, 1'b0);

    // Randomized traffic with occasional drops, burst_len churn, stalls and resets.
    do_reset();
    rr = 4'b0;
    bb = 16'(($urandom & 32'h3333));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rr[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) bb = 16'($urandom);
      cyc(rr, bb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
